phase_seq_arbiter: RTL
======================

# phase_seq_arbiter

Round-robin controller that shares the 2-bit phase sequencer (00 → 01 → 10 → 11 → 00) among N requesters. It accepts start requests from several clients and grants one at a time. It drives the phase walk with a programmable dwell per phase, and reports completion to the granted client. It sits between the client request lines and any logic decoding the phase code, and replaces a bare single-`start` sequencer wherever more than one client must trigger the sequence.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `CNT_W`, 4, width of the dwell counter and `hold_cycles`
- `ID_W`, `$clog2(N_REQ)`, width of `gnt_id` and `done_id`

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk` only
- `req`  in  N_REQ  per-requester start request; level, held until granted
- `hold_cycles`  in  CNT_W  extra dwell cycles per phase; sampled only at grant
- `gnt`  out  N_REQ  one-hot registered grant; high for the whole sequence
- `gnt_id`  out  ID_W  binary index of the current grantee; valid while `busy`
- `busy`  out  1  high while phase ≠ 00
- `phase`  out  2  current phase code (00 idle, 01, 10, 11)
- `done`  out  1  one-cycle pulse on return to phase 00
- `done_id`  out  ID_W  index of the requester whose sequence finished; valid with `done`

## Operation
- States: IDLE (phase 00), P1 (01), P2 (10), P3 (11). State is encoded directly as `phase`.
- IDLE with `req` ≠ 0: select the first set bit searching upward, with wrap, from `last+1`. On that edge:
  - `gnt`, `gnt_id`, `busy`=1 and phase=01 register.
  - `last` ← winner.
  - Dwell counter ← `hold_cycles`.
- IDLE with `req` = 0: remain idle. `gnt`=0, `busy`=0.
- P1/P2/P3 with counter > 0: decrement and hold the phase. With counter = 0: advance to the next phase and reload the counter from the value latched at grant. `hold_cycles` changes mid-sequence are ignored.
- P3 with counter = 0: on the next edge:
  - phase ← 00, `gnt` ← 0, `busy` ← 0.
  - `done` ← 1 for exactly one cycle.
  - `done_id` ← `gnt_id`.
- No abort. Dropping `req` while granted does not shorten or cancel the sequence. `req` bits of other clients are ignored until IDLE.
- Arbitration happens only in IDLE cycles. Every sequence is followed by at least one IDLE cycle (the `done` cycle). A new grant may register on the edge ending that cycle.
- Round-robin pointer `last` resets to N_REQ-1, so requester 0 has first priority after reset.
- Dwell arithmetic is unsigned CNT_W. Each phase lasts `hold_cycles`+1 cycles. Maximum dwell 2^CNT_W cycles per phase.

## Timing
- Reset (any state, including mid-sequence) takes effect on the next posedge:
  - phase=00, `gnt`=0, `gnt_id`=0, `busy`=0, `done`=0, `done_id`=0.
  - Counter=0, `last`=N_REQ-1.
  - No `done` is emitted for an aborted sequence.
- Grant latency: `req` high in IDLE at edge k → `gnt`/phase=01 visible after edge k.
- Sequence length with H = latched `hold_cycles`: 3·(H+1) cycles in P1..P3, then 1 `done` cycle in IDLE.
- Back-to-back throughput with continuous requests: one sequence per 3·(H+1)+1 cycles.
- `done` and a new `gnt` are never high in the same cycle.

## Test plan
- Reset values: hold `reset` 3 cycles with `req`=4'b1111 → all outputs 0 and phase=00 during reset. The first grant after release goes to requester 0.
- Single request, H=0: `req`=4'b0100 one cycle before edge k, then held:
  - `gnt`=4'b0100, `gnt_id`=2.
  - phase 01,10,11 on cycles k..k+2.
  - Cycle k+3: phase=00, `done`=1, `done_id`=2.
- Dwell, H=2: phase 01,01,01,10,10,10,11,11,11, then `done`. Changing `hold_cycles` to 0 in cycle 2 of P1 has no effect.
- Contention: `req`=4'b1111 held continuously, H=0 → grant order 0,1,2,3,0. Each sequence is separated by exactly one IDLE/`done` cycle.
- Withdrawal: requester 1 granted, then `req[1]` drops in P1 while `req[3]` rises → sequence for 1 completes (`done_id`=1). Next grant is 3.
- Reset mid-sequence: assert `reset` in P2 with H=3 → next edge phase=00, `done`=0. After release with `req`=4'b0001, grant goes to 0 with full 3·4 dwell.

Source files
------------

// File: rtl/phase_seq_arbiter.sv
// Round-robin front end for the 2-bit phase sequencer: grants one requester at a
// time and walks 01 -> 10 -> 11 -> 00 with a dwell of hold_cycles+1 per phase.
module phase_seq_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] hold_cycles,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic [1:0]       phase,
  output logic             done,
  output logic [ID_W-1:0]  done_id
);

  typedef enum logic [1:0] {IDLE = 2'b00, P1 = 2'b01, P2 = 2'b10, P3 = 2'b11} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d, last_q, last_d, done_id_q, done_id_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  win;
  logic             found;

  // First set request bit searching upward from last+1, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_q) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d     = P1;
          gnt_d[win]  = 1'b1;
          gnt_id_d    = win;
          last_d      = win;
          cnt_d       = hold_cycles;
          hold_d      = hold_cycles;
        end
      end
      P1, P2: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          state_d = (state_q == P1) ? P2 : P3;
          cnt_d   = hold_q;
        end
      end
      P3: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          state_d   = IDLE;
          cnt_d     = '0;
          gnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = gnt_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign phase   = state_q;
  assign busy    = (state_q != IDLE);
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
